player_mover: RTL and testbench

PLAYER_MOVER -- requirements
Module: player_mover

---
 rtl/player_mover.sv | 137 +++++++++++++
 tb/tb_player_mover.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/player_mover.sv
`default_nettype none
// ============================================================================
// Module : player_mover
// Steps a trail head one cell per tick, requests a pixel write at each new
// position and latches a crash on a wall or trail hit.
// Rev    : 1.0  initial release
// ============================================================================
module player_mover #(
  parameter logic [7:0] START_X  = 8'd40,
  parameter logic [6:0] START_Y  = 7'd60,
  parameter int         GRID_W   = 160,
  parameter int         GRID_H   = 120,
  parameter int         TICK_DIV = 3125000,
  parameter logic [2:0] COLOUR   = 3'b100
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  direction,
  input  logic        collide,
  input  logic        draw_ready,
  output logic        draw_valid,
  output logic [7:0]  draw_x,
  output logic [6:0]  draw_y,
  output logic [2:0]  draw_colour,
  output logic        crashed,
  output logic [15:0] steps
);

  localparam int            TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0]    X_MAX     = 8'(GRID_W - 1);
  localparam logic [6:0]    Y_MAX     = 7'(GRID_H - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DRAW      = 2'd1,
    ST_WAIT_TICK = 2'd2,
    ST_DEAD      = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      x_q, x_d;
  logic [6:0]      y_q, y_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [15:0]     steps_q, steps_d;
  logic            crashed_q, crashed_d;

  logic [7:0]      next_x;
  logic [6:0]      next_y;
  logic            wall_hit;

  // Candidate head for the current heading; wall_hit flags a move off-grid.
  always_comb begin
    next_x   = x_q;
    next_y   = y_q;
    wall_hit = 1'b0;
    case (direction)
      2'b00: begin wall_hit = (y_q == 7'd0);  next_y = y_q - 7'd1; end
      2'b01: begin wall_hit = (x_q == X_MAX); next_x = x_q + 8'd1; end
      2'b10: begin wall_hit = (y_q == Y_MAX); next_y = y_q + 7'd1; end
      default: begin wall_hit = (x_q == 8'd0); next_x = x_q - 8'd1; end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    tick_d    = tick_q;
    steps_d   = steps_q;
    crashed_d = crashed_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_DRAW;
      end
      ST_DRAW: begin
        if (collide) begin
          state_d   = ST_DEAD;
          crashed_d = 1'b1;
        end else if (draw_ready) begin
          state_d = ST_WAIT_TICK;
          tick_d  = '0;
        end
      end
      ST_WAIT_TICK: begin
        // Trail hit outranks the tick so a collision never advances the head.
        if (collide) begin
          state_d   = ST_DEAD;
          crashed_d = 1'b1;
        end else if (enable) begin
          if (tick_q == TICK_LAST) begin
            if (wall_hit) begin
              state_d   = ST_DEAD;
              crashed_d = 1'b1;
            end else begin
              state_d = ST_DRAW;
              x_d     = next_x;
              y_d     = next_y;
              if (steps_q != 16'hFFFF) steps_d = steps_q + 16'd1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      x_q       <= START_X;
      y_q       <= START_Y;
      tick_q    <= '0;
      steps_q   <= '0;
      crashed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      tick_q    <= tick_d;
      steps_q   <= steps_d;
      crashed_q <= crashed_d;
    end
  end

  assign draw_valid  = (state_q == ST_DRAW);
  assign draw_x      = x_q;
  assign draw_y      = y_q;
  assign draw_colour = COLOUR;
  assign crashed     = crashed_q;
  assign steps       = steps_q;

endmodule
`default_nettype wire

// File: tb/tb_player_mover.sv
`default_nettype none
// ============================================================================
// Module : tb_player_mover
// Self-checking bench for player_mover: vector table, directed corner cases
// and random traffic against a cell-grid reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_player_mover;

  localparam int A_TD = 4;
  localparam int A_W  = 160;
  localparam int A_H  = 120;
  localparam int A_SX = 40;
  localparam int A_SY = 60;
  localparam int B_TD = 3;
  localparam int B_W  = 4;
  localparam int B_H  = 64;
  localparam int B_SX = 0;
  localparam int B_SY = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable, collide, draw_ready;
  logic [1:0] direction;

  logic        a_valid, b_valid, a_crashed, b_crashed;
  logic [7:0]  a_x, b_x;
  logic [6:0]  a_y, b_y;
  logic [2:0]  a_col, b_col;
  logic [15:0] a_steps, b_steps;

  player_mover #(.TICK_DIV(A_TD)) dut_a (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .direction(direction),
    .collide(collide), .draw_ready(draw_ready), .draw_valid(a_valid),
    .draw_x(a_x), .draw_y(a_y), .draw_colour(a_col), .crashed(a_crashed),
    .steps(a_steps));

  player_mover #(.START_X(8'd0), .GRID_W(B_W), .GRID_H(B_H), .TICK_DIV(B_TD),
                 .COLOUR(3'b011)) dut_b (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .direction(direction),
    .collide(collide), .draw_ready(draw_ready), .draw_valid(b_valid),
    .draw_x(b_x), .draw_y(b_y), .draw_colour(b_col), .crashed(b_crashed),
    .steps(b_steps));

  int n_cmp = 0;
  int n_bad = 0;

  // phase: 0 idle, 1 drawing, 2 waiting for tick, 3 dead.
  // remaining: enabled wait cycles left including the one that moves.
  typedef struct {
    int phase;
    int x;
    int y;
    int remaining;
    int steps;
    bit crashed;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t m, bit rst, bit en, bit col, bit rdy,
                                 logic [1:0] dir, int W, int H, int TD,
                                 int SX, int SY);
    mdl_t n = m;
    int nx = m.x;
    int ny = m.y;
    if (rst) begin
      n.phase = 0; n.x = SX; n.y = SY; n.remaining = 0;
      n.steps = 0; n.crashed = 0;
      return n;
    end
    case (m.phase)
      0: if (en) n.phase = 1;
      1: begin
        if (col) begin n.phase = 3; n.crashed = 1; end
        else if (rdy) begin n.phase = 2; n.remaining = TD; end
      end
      2: begin
        if (col) begin n.phase = 3; n.crashed = 1; end
        else if (en) begin
          if (m.remaining == 1) begin
            case (dir)
              2'b00: ny = m.y - 1;
              2'b01: nx = m.x + 1;
              2'b10: ny = m.y + 1;
              default: nx = m.x - 1;
            endcase
            if (nx < 0 || nx >= W || ny < 0 || ny >= H) begin
              n.phase = 3; n.crashed = 1;
            end else begin
              n.x = nx; n.y = ny; n.phase = 1;
              n.steps = (m.steps >= 65535) ? 65535 : m.steps + 1;
            end
          end else begin
            n.remaining = m.remaining - 1;
          end
        end
      end
      default: ;
    endcase
    return n;
  endfunction

  task automatic chk(string tag, logic v, logic [7:0] x, logic [6:0] y,
                     logic c, logic [15:0] s, logic [2:0] cl,
                     bit ev, int ex, int ey, bit ec, int es, logic [2:0] ecl);
    n_cmp++;
    if ({v, x, y, c, s, cl} !== {ev, 8'(ex), 7'(ey), ec, 16'(es), ecl}) begin
      n_bad++;
      $display("FAIL %s: got valid=%0b head=(%0d,%0d) crashed=%0b steps=%0d colour=%0d, want valid=%0b head=(%0d,%0d) crashed=%0b steps=%0d colour=%0d",
               tag, v, x, y, c, s, cl, ev, ex, ey, ec, es, ecl);
    end
  endtask

  task automatic expect_int(string tag, int got, int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // One clock: drive inputs, advance both models, check both DUTs after edge.
  task automatic cyc(bit rst, bit en, bit col, bit rdy, logic [1:0] dir);
    reset = rst; enable = en; collide = col; draw_ready = rdy; direction = dir;
    ma = mstep(ma, rst, en, col, rdy, dir, A_W, A_H, A_TD, A_SX, A_SY);
    mb = mstep(mb, rst, en, col, rdy, dir, B_W, B_H, B_TD, B_SX, B_SY);
    @(posedge clk); #1;
    chk("model_a", a_valid, a_x, a_y, a_crashed, a_steps, a_col,
        ma.phase == 1, ma.x, ma.y, ma.crashed, ma.steps, 3'b100);
    chk("model_b", b_valid, b_x, b_y, b_crashed, b_steps, b_col,
        mb.phase == 1, mb.x, mb.y, mb.crashed, mb.steps, 3'b011);
  endtask

  // Cycles from WAIT_TICK entry to draw_valid rising, optional 5-cycle pause.
  task automatic measure(int pause_at, output int lat);
    lat = -1;
    cyc(1, 0, 0, 0, 2'b01);
    cyc(0, 1, 0, 1, 2'b01);
    cyc(0, 1, 0, 1, 2'b01);
    for (int k = 0; k < 50; k++) begin
      cyc(0, !(pause_at >= 0 && k >= pause_at && k < pause_at + 5), 0, 1, 2'b01);
      if (a_valid) begin lat = k + 1; break; end
    end
  endtask

  typedef struct {
    bit rst; bit en; bit col; bit rdy; logic [1:0] dir;
    bit ev; int ex; int ey; bit ec; int es;
  } vec_t;

  vec_t tbl [0:16];

  initial begin
    int lat0, lat1, cnt;
    reset = 1'b1; enable = 1'b0; collide = 1'b0; draw_ready = 1'b0;
    direction = 2'b00;
    @(posedge clk); #1;

    tbl = '{
      '{1, 0, 0, 0, 2'b01, 0, 40, 60, 0, 0},
      '{0, 1, 0, 1, 2'b01, 1, 40, 60, 0, 0},
      '{0, 1, 0, 1, 2'b01, 0, 40, 60, 0, 0},
      '{0, 1, 0, 1, 2'b01, 0, 40, 60, 0, 0},
      '{0, 1, 0, 1, 2'b01, 0, 40, 60, 0, 0},
      '{0, 1, 0, 1, 2'b01, 0, 40, 60, 0, 0},
      '{0, 1, 0, 1, 2'b01, 1, 41, 60, 0, 1},
      '{0, 1, 0, 1, 2'b10, 0, 41, 60, 0, 1},
      '{0, 1, 0, 0, 2'b10, 0, 41, 60, 0, 1},
      '{0, 1, 0, 0, 2'b10, 0, 41, 60, 0, 1},
      '{0, 1, 0, 0, 2'b10, 0, 41, 60, 0, 1},
      '{0, 1, 0, 0, 2'b10, 1, 41, 61, 0, 2},
      '{0, 0, 0, 0, 2'b10, 1, 41, 61, 0, 2},
      '{0, 0, 1, 0, 2'b10, 0, 41, 61, 1, 2},
      '{0, 1, 0, 1, 2'b10, 0, 41, 61, 1, 2},
      '{1, 1, 0, 1, 2'b10, 0, 40, 60, 0, 0},
      '{0, 0, 0, 1, 2'b10, 0, 40, 60, 0, 0}
    };
    for (int i = 0; i <= 16; i++) begin
      cyc(tbl[i].rst, tbl[i].en, tbl[i].col, tbl[i].rdy, tbl[i].dir);
      chk($sformatf("vec%0d", i), a_valid, a_x, a_y, a_crashed, a_steps, a_col,
          tbl[i].ev, tbl[i].ex, tbl[i].ey, tbl[i].ec, tbl[i].es, 3'b100);
    end

    // Request held stable while the writer stalls.
    cyc(1, 0, 0, 0, 2'b01);
    cyc(0, 1, 0, 0, 2'b01);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 1'($urandom_range(0, 1)), 0, 0, 2'b01);
      chk("stall_hold", a_valid, a_x, a_y, a_crashed, a_steps, a_col,
          1, 40, 60, 0, 0, 3'b100);
    end

    // Left wall crash from column 0.
    cyc(1, 0, 0, 0, 2'b11);
    cyc(0, 1, 0, 1, 2'b11);
    cyc(0, 1, 0, 1, 2'b11);
    cnt = 0;
    while (!b_crashed && cnt < 20) begin
      cyc(0, 1, 0, 1, 2'b11);
      cnt++;
    end
    expect_int("wall_latency", cnt, B_TD);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 1, 0, 1, 2'b11);
      chk("wall_dead", b_valid, b_x, b_y, b_crashed, b_steps, b_col,
          0, 0, 60, 1, 0, 3'b011);
    end

    // Collision on the terminal tick beats the move.
    cyc(1, 0, 0, 0, 2'b01);
    cyc(0, 1, 0, 1, 2'b01);
    cyc(0, 1, 0, 1, 2'b01);
    for (int i = 0; i < A_TD - 1; i++) cyc(0, 1, 0, 1, 2'b01);
    cyc(0, 1, 1, 1, 2'b01);
    chk("collide_tick", a_valid, a_x, a_y, a_crashed, a_steps, a_col,
        0, 40, 60, 1, 0, 3'b100);
    cyc(0, 1, 0, 1, 2'b01);
    chk("collide_hold", a_valid, a_x, a_y, a_crashed, a_steps, a_col,
        0, 40, 60, 1, 0, 3'b100);

    // Pause stretches the step by exactly the paused cycles.
    measure(-1, lat0);
    measure(2, lat1);
    expect_int("latency_plain", lat0, A_TD);
    expect_int("latency_paused", lat1, A_TD + 5);

    // Reset during an outstanding request.
    cyc(1, 0, 0, 0, 2'b10);
    cyc(0, 1, 0, 0, 2'b10);
    cyc(1, 1, 0, 0, 2'b10);
    chk("reset_mid", a_valid, a_x, a_y, a_crashed, a_steps, a_col,
        0, 40, 60, 0, 0, 3'b100);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 2'b10);
      chk("idle_wait", a_valid, a_x, a_y, a_crashed, a_steps, a_col,
          0, 40, 60, 0, 0, 3'b100);
    end
    cyc(0, 1, 0, 0, 2'b10);
    chk("idle_leave", a_valid, a_x, a_y, a_crashed, a_steps, a_col,
        1, 40, 60, 0, 0, 3'b100);

    // Random traffic against the model.
    cyc(1, 0, 0, 0, 2'b00);
    for (int i = 0; i < 4000; i++) begin
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0,
          $urandom_range(0, 79) == 0, $urandom_range(0, 1) == 1,
          2'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
